// File: rtl/rob_multi.sv
// Multi-commit reorder buffer: tail issue, multi-port writeback, in-order
// retirement of up to COMMIT_WIDTH entries and a registered operand-dependence query.

module rob_multi_qlane #(
   parameter int ROB_WIDTH = 3,
   parameter int WB_PORTS  = 2,
   parameter int XLEN      = 32
) (
   input  logic                          has_dep_i,
   input  logic [ROB_WIDTH-1:0]          id_i,
   input  logic [XLEN-1:0]               val_i,
   input  logic [WB_PORTS-1:0]           wb_valid_i,
   input  logic [WB_PORTS*ROB_WIDTH-1:0] wb_rob_id_i,
   input  logic [WB_PORTS*XLEN-1:0]      wb_value_i,
   input  logic                          ent_done_i,
   input  logic [XLEN-1:0]               ent_val_i,
   output logic                          has_dep_o,
   output logic [ROB_WIDTH-1:0]          dep_o,
   output logic [XLEN-1:0]               val_o
);
   logic            hit;
   logic [XLEN-1:0] hit_val;

   always_comb begin
      hit     = 1'b0;
      hit_val = '0;
      // scan high to low so the lowest matching port wins
      for (int k = WB_PORTS-1; k >= 0; k--) begin
         if (wb_valid_i[k] && (wb_rob_id_i[k*ROB_WIDTH +: ROB_WIDTH] == id_i)) begin
            hit     = 1'b1;
            hit_val = wb_value_i[k*XLEN +: XLEN];
         end
      end
      has_dep_o = 1'b0;
      dep_o     = '0;
      val_o     = val_i;
      if (has_dep_i) begin
         if (hit)             val_o = hit_val;
         else if (ent_done_i) val_o = ent_val_i;
         else begin
            has_dep_o = 1'b1;
            dep_o     = id_i;
            val_o     = '0;
         end
      end
   end
endmodule

module rob_multi #(
   parameter int ROB_WIDTH    = 3,
   parameter int WB_PORTS     = 2,
   parameter int COMMIT_WIDTH = 2,
   parameter int XLEN         = 32
) (
   input  logic                              clk_in,
   input  logic                              rst_n_in,
   input  logic                              rdy_in,
   input  logic                              iss_valid,
   input  logic [1:0]                        iss_type,
   input  logic [4:0]                        iss_rd,
   input  logic [XLEN-1:0]                   iss_jaddr,
   output logic                              rob_full,
   output logic [ROB_WIDTH-1:0]              empty_rob_id,
   output logic [ROB_WIDTH-1:0]              head_rob_id,
   output logic [ROB_WIDTH:0]                rob_count,
   input  logic [WB_PORTS-1:0]               wb_valid,
   input  logic [WB_PORTS*ROB_WIDTH-1:0]     wb_rob_id,
   input  logic [WB_PORTS*XLEN-1:0]          wb_value,
   input  logic [1:0]                        q_has_dep_in,
   input  logic [2*ROB_WIDTH-1:0]            q_rob_id_in,
   input  logic [2*XLEN-1:0]                 q_val_in,
   output logic [1:0]                        q_has_dep_out,
   output logic [2*ROB_WIDTH-1:0]            q_dep_out,
   output logic [2*XLEN-1:0]                 q_val_out,
   output logic [COMMIT_WIDTH-1:0]           cmt_valid,
   output logic [COMMIT_WIDTH*ROB_WIDTH-1:0] cmt_rob_id,
   output logic [COMMIT_WIDTH*5-1:0]         cmt_rd,
   output logic [COMMIT_WIDTH*XLEN-1:0]      cmt_val,
   output logic                              st_commit,
   output logic [ROB_WIDTH-1:0]              st_rob_id,
   output logic                              flush_out,
   output logic                              melt_out,
   output logic [XLEN-1:0]                   redirect_pc
);
   localparam int RW    = ROB_WIDTH;
   localparam int DEPTH = 2**ROB_WIDTH;

   typedef enum logic [1:0] {T_BR = 2'd0, T_ST = 2'd1, T_JALR = 2'd2, T_RG = 2'd3} rtype_e;

   logic [RW-1:0]                 head_q, head_d, tail_q, tail_d;
   logic [RW:0]                   count_q, count_d;
   logic [DEPTH-1:0]              busy_q, busy_d, wr_q, wr_d;
   logic [DEPTH-1:0][1:0]         typ_q, typ_d;
   logic [DEPTH-1:0][4:0]         rd_q, rd_d;
   logic [DEPTH-1:0][XLEN-1:0]    val_q, val_d, jad_q, jad_d;

   logic [COMMIT_WIDTH-1:0]       cv_q, cv_d;
   logic [COMMIT_WIDTH*RW-1:0]    cid_q, cid_d;
   logic [COMMIT_WIDTH*5-1:0]     crd_q, crd_d;
   logic [COMMIT_WIDTH*XLEN-1:0]  cval_q, cval_d;
   logic                          st_q, st_d, fl_q, fl_d, melt_q, melt_d;
   logic [RW-1:0]                 sid_q, sid_d;
   logic [XLEN-1:0]               rpc_q, rpc_d;
   logic [1:0]                    qh_q, qh_d;
   logic [2*RW-1:0]               qd_q, qd_d;
   logic [2*XLEN-1:0]             qv_q, qv_d;

   logic          iss_ok, ret0, ret1, mispred;
   logic [1:0]    rets, n_ret;
   logic [RW-1:0] h1, wid, sid;

   assign rob_full     = (count_q == (RW+1)'(DEPTH));
   assign empty_rob_id = tail_q;
   assign head_rob_id  = head_q;
   assign iss_ok       = iss_valid && !rob_full;
   assign h1           = head_q + RW'(1);

   // slot 1 only pairs a plain register write behind a non-control head
   assign ret0    = busy_q[head_q] && wr_q[head_q];
   assign ret1    = (COMMIT_WIDTH == 2) && ret0 &&
                    ((typ_q[head_q] == T_RG) || (typ_q[head_q] == T_ST)) &&
                    busy_q[h1] && wr_q[h1] && (typ_q[h1] == T_RG);
   assign mispred = ret0 && (typ_q[head_q] == T_BR) && (val_q[head_q] != jad_q[head_q]);
   assign rets    = {ret1, ret0};
   assign n_ret   = {1'b0, ret0} + {1'b0, ret1};

   always_comb begin
      head_d = head_q;  tail_d = tail_q;  count_d = count_q;
      busy_d = busy_q;  wr_d   = wr_q;    typ_d   = typ_q;
      rd_d   = rd_q;    val_d  = val_q;   jad_d   = jad_q;
      cv_d   = '0;      cid_d  = cid_q;   crd_d   = crd_q;   cval_d = cval_q;
      st_d   = 1'b0;    sid_d  = sid_q;   fl_d    = 1'b0;    melt_d = 1'b0;
      rpc_d  = rpc_q;   wid    = '0;      sid     = '0;

      for (int k = WB_PORTS-1; k >= 0; k--) begin
         wid = wb_rob_id[k*RW +: RW];
         if (wb_valid[k] && busy_q[wid]) begin
            wr_d[wid]  = 1'b1;
            val_d[wid] = wb_value[k*XLEN +: XLEN];
         end
      end

      if (iss_ok) begin
         busy_d[tail_q] = 1'b1;
         wr_d[tail_q]   = 1'b0;
         typ_d[tail_q]  = iss_type;
         rd_d[tail_q]   = iss_rd;
         val_d[tail_q]  = '0;
         jad_d[tail_q]  = iss_jaddr;
         tail_d         = tail_q + RW'(1);
      end

      for (int s = 0; s < COMMIT_WIDTH; s++) begin
         sid = head_q + RW'(s);
         if (rets[s]) begin
            busy_d[sid] = 1'b0;
            if ((typ_q[sid] == T_RG) || (typ_q[sid] == T_JALR)) begin
               cv_d[s]                = 1'b1;
               cid_d[s*RW +: RW]      = sid;
               crd_d[s*5 +: 5]        = rd_q[sid];
               cval_d[s*XLEN +: XLEN] = (typ_q[sid] == T_JALR) ? jad_q[sid] : val_q[sid];
            end
         end
      end

      if (ret0 && (typ_q[head_q] == T_ST)) begin
         st_d  = 1'b1;
         sid_d = head_q;
      end
      if (ret0 && (typ_q[head_q] == T_JALR)) begin
         melt_d = 1'b1;
         rpc_d  = val_q[head_q];
      end
      head_d  = head_q + RW'(n_ret);
      count_d = count_q + (RW+1)'(iss_ok) - (RW+1)'(n_ret);

      // mispredict squashes everything, including this cycle's issue and writebacks
      if (mispred) begin
         fl_d    = 1'b1;
         rpc_d   = val_q[head_q];
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
         busy_d  = '0;
         wr_d    = '0;
      end
   end

   for (genvar j = 0; j < 2; j++) begin : g_q
      rob_multi_qlane #(.ROB_WIDTH(RW), .WB_PORTS(WB_PORTS), .XLEN(XLEN)) u_lane (
         .has_dep_i  (q_has_dep_in[j]),
         .id_i       (q_rob_id_in[j*RW +: RW]),
         .val_i      (q_val_in[j*XLEN +: XLEN]),
         .wb_valid_i (wb_valid),
         .wb_rob_id_i(wb_rob_id),
         .wb_value_i (wb_value),
         .ent_done_i (busy_q[q_rob_id_in[j*RW +: RW]] && wr_q[q_rob_id_in[j*RW +: RW]]),
         .ent_val_i  (val_q[q_rob_id_in[j*RW +: RW]]),
         .has_dep_o  (qh_d[j]),
         .dep_o      (qd_d[j*RW +: RW]),
         .val_o      (qv_d[j*XLEN +: XLEN])
      );
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         head_q <= '0;  tail_q <= '0;  count_q <= '0;
         busy_q <= '0;  wr_q   <= '0;  typ_q   <= '0;
         rd_q   <= '0;  val_q  <= '0;  jad_q   <= '0;
         cv_q   <= '0;  cid_q  <= '0;  crd_q   <= '0;  cval_q <= '0;
         st_q   <= 1'b0; sid_q <= '0;  fl_q    <= 1'b0; melt_q <= 1'b0;
         rpc_q  <= '0;  qh_q   <= '0;  qd_q    <= '0;  qv_q   <= '0;
      end else if (rdy_in) begin
         head_q <= head_d;  tail_q <= tail_d;  count_q <= count_d;
         busy_q <= busy_d;  wr_q   <= wr_d;    typ_q   <= typ_d;
         rd_q   <= rd_d;    val_q  <= val_d;   jad_q   <= jad_d;
         cv_q   <= cv_d;    cid_q  <= cid_d;   crd_q   <= crd_d;   cval_q <= cval_d;
         st_q   <= st_d;    sid_q  <= sid_d;   fl_q    <= fl_d;    melt_q <= melt_d;
         rpc_q  <= rpc_d;   qh_q   <= qh_d;    qd_q    <= qd_d;    qv_q   <= qv_d;
      end
   end

   assign rob_count     = count_q;
   assign cmt_valid     = cv_q;
   assign cmt_rob_id    = cid_q;
   assign cmt_rd        = crd_q;
   assign cmt_val       = cval_q;
   assign st_commit     = st_q;
   assign st_rob_id     = sid_q;
   assign flush_out     = fl_q;
   assign melt_out      = melt_q;
   assign redirect_pc   = rpc_q;
   assign q_has_dep_out = qh_q;
   assign q_dep_out     = qd_q;
   assign q_val_out     = qv_q;
endmodule

// File: tb/tb_rob_multi.sv
// Bench for rob_multi: directed scenarios plus random traffic against a queue-based model.
module tb_rob_multi;
   localparam int RW = 3, WP = 2, CW = 2, XL = 32, D = 8;
   localparam logic [1:0] BR = 2'd0, ST = 2'd1, JR = 2'd2, RG = 2'd3;

   logic              clk_in = 1'b0, rst_n_in, rdy_in;
   logic              iss_valid;
   logic [1:0]        iss_type;
   logic [4:0]        iss_rd;
   logic [XL-1:0]     iss_jaddr;
   logic              rob_full;
   logic [RW-1:0]     empty_rob_id, head_rob_id;
   logic [RW:0]       rob_count;
   logic [WP-1:0]     wb_valid;
   logic [WP*RW-1:0]  wb_rob_id;
   logic [WP*XL-1:0]  wb_value;
   logic [1:0]        q_has_dep_in, q_has_dep_out;
   logic [2*RW-1:0]   q_rob_id_in, q_dep_out;
   logic [2*XL-1:0]   q_val_in, q_val_out;
   logic [CW-1:0]     cmt_valid;
   logic [CW*RW-1:0]  cmt_rob_id;
   logic [CW*5-1:0]   cmt_rd;
   logic [CW*XL-1:0]  cmt_val;
   logic              st_commit, flush_out, melt_out;
   logic [RW-1:0]     st_rob_id;
   logic [XL-1:0]     redirect_pc;

   rob_multi #(.ROB_WIDTH(RW), .WB_PORTS(WP), .COMMIT_WIDTH(CW), .XLEN(XL)) dut (
      .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
      .iss_valid(iss_valid), .iss_type(iss_type), .iss_rd(iss_rd), .iss_jaddr(iss_jaddr),
      .rob_full(rob_full), .empty_rob_id(empty_rob_id), .head_rob_id(head_rob_id),
      .rob_count(rob_count), .wb_valid(wb_valid), .wb_rob_id(wb_rob_id), .wb_value(wb_value),
      .q_has_dep_in(q_has_dep_in), .q_rob_id_in(q_rob_id_in), .q_val_in(q_val_in),
      .q_has_dep_out(q_has_dep_out), .q_dep_out(q_dep_out), .q_val_out(q_val_out),
      .cmt_valid(cmt_valid), .cmt_rob_id(cmt_rob_id), .cmt_rd(cmt_rd), .cmt_val(cmt_val),
      .st_commit(st_commit), .st_rob_id(st_rob_id), .flush_out(flush_out),
      .melt_out(melt_out), .redirect_pc(redirect_pc)
   );

   always #5 clk_in = ~clk_in;

   int total = 0, bad = 0;

   typedef struct {
      logic [RW-1:0] id;
      logic [1:0]    t;
      logic [4:0]    rd;
      logic [XL-1:0] val, ja;
      bit            done;
   } ent_t;
   ent_t mq[$];
   int   mhead;

   logic [CW-1:0] e_cv;
   logic [RW-1:0] e_cid [CW];
   logic [4:0]    e_crd [CW];
   logic [XL-1:0] e_cval[CW];
   logic          e_st, e_fl, e_me;
   logic [RW-1:0] e_sid;
   logic [XL-1:0] e_rpc;
   logic [1:0]    e_qh;
   logic [RW-1:0] e_qd[2];
   logic [XL-1:0] e_qv[2];

   task automatic cyc;
      @(posedge clk_in);
      @(negedge clk_in);
   endtask

   task automatic idle;
      rdy_in = 1'b1; iss_valid = 1'b0; iss_type = RG; iss_rd = '0; iss_jaddr = '0;
      wb_valid = '0; wb_rob_id = '0; wb_value = '0;
      q_has_dep_in = '0; q_rob_id_in = '0; q_val_in = '0;
   endtask

   task automatic do_reset;
      idle();
      rst_n_in = 1'b0;
      cyc();
      rst_n_in = 1'b1;
   endtask

   task automatic issue(input logic [1:0] t, input logic [4:0] rd, input logic [XL-1:0] ja);
      iss_valid = 1'b1; iss_type = t; iss_rd = rd; iss_jaddr = ja;
      cyc();
      iss_valid = 1'b0;
   endtask

   task automatic test_reset;
      do_reset();
      issue(RG, 5'd4, 32'h0);
      wb_valid = 2'b01; wb_rob_id = {3'd0, 3'd0}; wb_value = {32'h0, 32'h99};
      q_has_dep_in = 2'b00; q_val_in = {32'h0, 32'hDEAD};
      cyc();
      idle();
      cyc();
      total++; if (cmt_valid !== 2'b01) begin bad++; $display("FAIL pre_reset_cmt got=%b want=01", cmt_valid); end
      #2 rst_n_in = 1'b0;
      #1;
      total++; if (rob_count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", rob_count); end
      total++; if (empty_rob_id !== 3'd0) begin bad++; $display("FAIL reset_tail got=%0d want=0", empty_rob_id); end
      total++; if (cmt_valid !== 2'b00 || cmt_val !== 64'h0 || cmt_rd !== 10'h0) begin bad++; $display("FAIL reset_cmt got=%b/%h want=0", cmt_valid, cmt_val); end
      total++; if (q_val_out !== 64'h0 || q_has_dep_out !== 2'b00) begin bad++; $display("FAIL reset_query got=%h want=0", q_val_out); end
      total++; if ({st_commit, flush_out, melt_out, rob_full} !== 4'b0 || redirect_pc !== 32'h0) begin bad++; $display("FAIL reset_pulses got=%b want=0", {st_commit, flush_out, melt_out, rob_full}); end
      @(negedge clk_in);
      rst_n_in = 1'b1;
   endtask

   task automatic test_fill;
      do_reset();
      for (int i = 0; i < 7; i++) issue(RG, 5'(i + 1), 32'h0);
      total++; if (rob_full !== 1'b0 || rob_count !== 4'd7) begin bad++; $display("FAIL fill7 got=%b/%0d want=0/7", rob_full, rob_count); end
      issue(RG, 5'd8, 32'h0);
      total++; if (rob_full !== 1'b1 || rob_count !== 4'd8) begin bad++; $display("FAIL fill8 got=%b/%0d want=1/8", rob_full, rob_count); end
      total++; if (empty_rob_id !== 3'd0) begin bad++; $display("FAIL fill8_tail got=%0d want=0", empty_rob_id); end
      issue(RG, 5'd9, 32'h0);
      total++; if (rob_count !== 4'd8 || empty_rob_id !== 3'd0 || head_rob_id !== 3'd0) begin bad++; $display("FAIL fill9_drop got=%0d/%0d want=8/0", rob_count, empty_rob_id); end
   endtask

   task automatic test_dual_commit;
      do_reset();
      issue(RG, 5'd1, 32'h0);
      issue(RG, 5'd2, 32'h0);
      wb_valid = 2'b11; wb_rob_id = {3'd1, 3'd0}; wb_value = {32'hB, 32'hA};
      cyc();
      wb_valid = 2'b00;
      total++; if (cmt_valid !== 2'b00 || rob_count !== 4'd2) begin bad++; $display("FAIL dual_pre got=%b/%0d want=00/2", cmt_valid, rob_count); end
      cyc();
      total++; if (cmt_valid !== 2'b11) begin bad++; $display("FAIL dual_valid got=%b want=11", cmt_valid); end
      total++; if (cmt_val !== {32'hB, 32'hA} || cmt_rd !== {5'd2, 5'd1} || cmt_rob_id !== {3'd1, 3'd0}) begin bad++; $display("FAIL dual_data got=%h/%h want=0000000b0000000a", cmt_val, cmt_rd); end
      total++; if (rob_count !== 4'd0 || head_rob_id !== 3'd2) begin bad++; $display("FAIL dual_count got=%0d/%0d want=0/2", rob_count, head_rob_id); end
      cyc();
      total++; if (cmt_valid !== 2'b00 || cmt_val !== {32'hB, 32'hA}) begin bad++; $display("FAIL dual_hold got=%b/%h want=00/held", cmt_valid, cmt_val); end
   endtask

   task automatic test_mispredict;
      do_reset();
      issue(BR, 5'd0, 32'h100);
      issue(RG, 5'd5, 32'h0);
      wb_valid = 2'b11; wb_rob_id = {3'd1, 3'd0}; wb_value = {32'h77, 32'h200};
      cyc();
      wb_valid = 2'b00;
      total++; if (flush_out !== 1'b0 || rob_count !== 4'd2) begin bad++; $display("FAIL misp_pre got=%b/%0d want=0/2", flush_out, rob_count); end
      iss_valid = 1'b1; iss_type = RG; iss_rd = 5'd6;
      cyc();
      iss_valid = 1'b0;
      total++; if (flush_out !== 1'b1 || redirect_pc !== 32'h200) begin bad++; $display("FAIL misp_flush got=%b/%h want=1/200", flush_out, redirect_pc); end
      total++; if (rob_count !== 4'd0 || empty_rob_id !== 3'd0 || head_rob_id !== 3'd0) begin bad++; $display("FAIL misp_state got=%0d/%0d want=0/0", rob_count, empty_rob_id); end
      total++; if (cmt_valid !== 2'b00) begin bad++; $display("FAIL misp_cmt got=%b want=00", cmt_valid); end
      cyc();
      total++; if (flush_out !== 1'b0 || cmt_valid !== 2'b00 || rob_count !== 4'd0) begin bad++; $display("FAIL misp_after got=%b/%b/%0d want=0/00/0", flush_out, cmt_valid, rob_count); end
      cyc();
      total++; if (cmt_valid !== 2'b00) begin bad++; $display("FAIL misp_young got=%b want=00", cmt_valid); end
   endtask

   task automatic test_query_bypass;
      do_reset();
      for (int i = 0; i < 4; i++) issue(RG, 5'(i + 1), 32'h0);
      q_has_dep_in = 2'b11; q_rob_id_in = {3'd2, 3'd3}; q_val_in = {32'hAAAA, 32'hBBBB};
      wb_valid = 2'b10; wb_rob_id = {3'd3, 3'd0}; wb_value = {32'h55, 32'h0};
      cyc();
      wb_valid = 2'b00;
      total++; if (q_has_dep_out !== 2'b10 || q_val_out !== {32'h0, 32'h55}) begin bad++; $display("FAIL qry_bypass got=%b/%h want=10/55", q_has_dep_out, q_val_out); end
      total++; if (q_dep_out !== {3'd2, 3'd0}) begin bad++; $display("FAIL qry_dep got=%h want=10", q_dep_out); end
      q_has_dep_in = 2'b01; q_rob_id_in = {3'd0, 3'd3}; q_val_in = {32'h1234, 32'h0};
      cyc();
      total++; if (q_has_dep_out !== 2'b00 || q_val_out !== {32'h1234, 32'h55} || q_dep_out !== 6'h0) begin bad++; $display("FAIL qry_stored got=%b/%h want=00/1234_55", q_has_dep_out, q_val_out); end
      q_has_dep_in = 2'b01; q_rob_id_in = {3'd0, 3'd2};
      wb_valid = 2'b11; wb_rob_id = {3'd2, 3'd2}; wb_value = {32'h20, 32'h10};
      cyc();
      wb_valid = 2'b00;
      total++; if (q_val_out[31:0] !== 32'h10) begin bad++; $display("FAIL qry_prio got=%h want=10", q_val_out[31:0]); end
      cyc();
      total++; if (q_val_out[31:0] !== 32'h10 || q_has_dep_out[0] !== 1'b0) begin bad++; $display("FAIL wb_prio got=%h want=10", q_val_out[31:0]); end
   endtask

   task automatic test_store_pair;
      do_reset();
      issue(ST, 5'd0, 32'h0);
      issue(ST, 5'd0, 32'h0);
      issue(JR, 5'd9, 32'h44);
      wb_valid = 2'b11; wb_rob_id = {3'd1, 3'd0}; wb_value = {32'h22, 32'h11};
      cyc();
      wb_valid = 2'b01; wb_rob_id = {3'd0, 3'd2}; wb_value = {32'h0, 32'h300};
      cyc();
      wb_valid = 2'b00;
      total++; if (st_commit !== 1'b1 || st_rob_id !== 3'd0 || cmt_valid !== 2'b00 || rob_count !== 4'd2) begin bad++; $display("FAIL st_first got=%b/%0d/%b/%0d want=1/0/00/2", st_commit, st_rob_id, cmt_valid, rob_count); end
      cyc();
      total++; if (st_commit !== 1'b1 || st_rob_id !== 3'd1 || rob_count !== 4'd1) begin bad++; $display("FAIL st_second got=%b/%0d/%0d want=1/1/1", st_commit, st_rob_id, rob_count); end
      cyc();
      total++; if (melt_out !== 1'b1 || redirect_pc !== 32'h300 || st_commit !== 1'b0) begin bad++; $display("FAIL jalr_melt got=%b/%h want=1/300", melt_out, redirect_pc); end
      total++; if (cmt_valid !== 2'b01 || cmt_val[31:0] !== 32'h44 || cmt_rd[4:0] !== 5'd9) begin bad++; $display("FAIL jalr_cmt got=%b/%h/%0d want=01/44/9", cmt_valid, cmt_val[31:0], cmt_rd[4:0]); end
      issue(ST, 5'd0, 32'h0);
      issue(RG, 5'd3, 32'h0);
      total++; if (melt_out !== 1'b0) begin bad++; $display("FAIL jalr_pulse got=%b want=0", melt_out); end
      wb_valid = 2'b11; wb_rob_id = {3'd4, 3'd3}; wb_value = {32'h66, 32'h5};
      cyc();
      wb_valid = 2'b00;
      cyc();
      total++; if (st_commit !== 1'b1 || st_rob_id !== 3'd3 || cmt_valid !== 2'b10) begin bad++; $display("FAIL st_rg_pair got=%b/%0d/%b want=1/3/10", st_commit, st_rob_id, cmt_valid); end
      total++; if (cmt_val[63:32] !== 32'h66 || cmt_rd[9:5] !== 5'd3 || cmt_rob_id[5:3] !== 3'd4 || rob_count !== 4'd0) begin bad++; $display("FAIL st_rg_data got=%h/%0d/%0d want=66/3/0", cmt_val[63:32], cmt_rd[9:5], rob_count); end
   endtask

   task automatic model_step;
      int sz, tail, nret;
      bit r0, r1, found;
      ent_t e, h;
      logic [RW-1:0] qid;
      if (!rdy_in) return;
      sz = mq.size();
      tail = (mhead + sz) % D;
      for (int j = 0; j < 2; j++) begin
         qid = q_rob_id_in[j*RW +: RW];
         e_qh[j] = 1'b0; e_qd[j] = '0; e_qv[j] = q_val_in[j*XL +: XL];
         if (q_has_dep_in[j]) begin
            found = 0;
            for (int k = 0; k < WP; k++)
               if (!found && wb_valid[k] && wb_rob_id[k*RW +: RW] == qid) begin found = 1; e_qv[j] = wb_value[k*XL +: XL]; end
            for (int n = 0; n < sz; n++)
               if (!found && mq[n].id == qid && mq[n].done) begin found = 1; e_qv[j] = mq[n].val; end
            if (!found) begin e_qh[j] = 1'b1; e_qd[j] = qid; e_qv[j] = '0; end
         end
      end
      e_cv = '0; e_st = 0; e_fl = 0; e_me = 0;
      r0 = 0; r1 = 0;
      if (sz > 0) r0 = mq[0].done;
      if (r0 && sz > 1) r1 = (mq[0].t == RG || mq[0].t == ST) && mq[1].done && mq[1].t == RG;
      nret = int'(r0) + int'(r1);
      for (int s = 0; s < nret; s++) begin
         h = mq[s];
         if (h.t == RG || h.t == JR) begin
            e_cv[s] = 1'b1; e_cid[s] = h.id; e_crd[s] = h.rd;
            e_cval[s] = (h.t == JR) ? h.ja : h.val;
         end
         if (h.t == JR) begin e_me = 1; e_rpc = h.val; end
         if (h.t == ST) begin e_st = 1; e_sid = h.id; end
         if (h.t == BR && h.val != h.ja) begin e_fl = 1; e_rpc = h.val; end
      end
      if (e_fl) begin
         mq.delete();
         mhead = 0;
         return;
      end
      for (int n = 0; n < sz; n++) begin
         e = mq[n];
         found = 0;
         for (int k = 0; k < WP; k++)
            if (!found && wb_valid[k] && wb_rob_id[k*RW +: RW] == e.id) begin found = 1; e.done = 1; e.val = wb_value[k*XL +: XL]; end
         mq[n] = e;
      end
      repeat (nret) void'(mq.pop_front());
      mhead = (mhead + nret) % D;
      if (iss_valid && sz < D) begin
         e.id = RW'(tail); e.t = iss_type; e.rd = iss_rd; e.val = '0; e.ja = iss_jaddr; e.done = 0;
         mq.push_back(e);
      end
   endtask

   function automatic logic [RW-1:0] pick_id();
      if (mq.size() > 0 && $urandom_range(0, 3) != 0) return mq[$urandom_range(0, mq.size() - 1)].id;
      return RW'($urandom);
   endfunction

   function automatic logic [XL-1:0] pick_val();
      case ($urandom_range(0, 3))
         1: return 32'h100;
         2: return 32'h200;
         default: return $urandom;
      endcase
   endfunction

   task automatic test_random(input int n);
      int tsel;
      do_reset();
      mq.delete(); mhead = 0;
      e_cv = '0; e_st = 0; e_fl = 0; e_me = 0; e_sid = '0; e_rpc = '0; e_qh = '0;
      for (int s = 0; s < CW; s++) begin e_cid[s] = '0; e_crd[s] = '0; e_cval[s] = '0; end
      for (int i = 0; i < n; i++) begin
         rdy_in    = ($urandom_range(0, 9) != 0);
         iss_valid = ($urandom_range(0, 9) < 6);
         tsel      = $urandom_range(0, 19);
         iss_type  = (tsel < 3) ? BR : (tsel < 6) ? ST : (tsel < 8) ? JR : RG;
         iss_rd    = 5'($urandom);
         iss_jaddr = $urandom_range(0, 1) ? 32'h100 : 32'h200;
         for (int k = 0; k < WP; k++) begin
            wb_valid[k] = ($urandom_range(0, 2) != 0);
            wb_rob_id[k*RW +: RW] = pick_id();
            wb_value[k*XL +: XL] = pick_val();
         end
         q_has_dep_in = 2'($urandom);
         for (int j = 0; j < 2; j++) begin
            q_rob_id_in[j*RW +: RW] = pick_id();
            q_val_in[j*XL +: XL] = $urandom;
         end
         model_step();
         cyc();
         total++; if (rob_count !== 4'(mq.size()) || rob_full !== (mq.size() == D)) begin bad++; $display("FAIL rnd_count cyc=%0d got=%0d want=%0d", i, rob_count, mq.size()); end
         total++; if (empty_rob_id !== RW'((mhead + mq.size()) % D) || head_rob_id !== RW'(mhead)) begin bad++; $display("FAIL rnd_ptrs cyc=%0d got=%0d/%0d want=%0d/%0d", i, head_rob_id, empty_rob_id, mhead, (mhead + mq.size()) % D); end
         total++; if (cmt_valid !== e_cv) begin bad++; $display("FAIL rnd_cmt_valid cyc=%0d got=%b want=%b", i, cmt_valid, e_cv); end
         for (int s = 0; s < CW; s++) begin
            total++; if (cmt_rob_id[s*RW +: RW] !== e_cid[s] || cmt_rd[s*5 +: 5] !== e_crd[s] || cmt_val[s*XL +: XL] !== e_cval[s]) begin bad++; $display("FAIL rnd_cmt_slot%0d cyc=%0d got=%0d/%0d/%h want=%0d/%0d/%h", s, i, cmt_rob_id[s*RW +: RW], cmt_rd[s*5 +: 5], cmt_val[s*XL +: XL], e_cid[s], e_crd[s], e_cval[s]); end
         end
         total++; if ({st_commit, flush_out, melt_out} !== {e_st, e_fl, e_me}) begin bad++; $display("FAIL rnd_pulses cyc=%0d got=%b want=%b", i, {st_commit, flush_out, melt_out}, {e_st, e_fl, e_me}); end
         if (e_st) begin total++; if (st_rob_id !== e_sid) begin bad++; $display("FAIL rnd_st_id cyc=%0d got=%0d want=%0d", i, st_rob_id, e_sid); end end
         if (e_fl || e_me) begin total++; if (redirect_pc !== e_rpc) begin bad++; $display("FAIL rnd_redirect cyc=%0d got=%h want=%h", i, redirect_pc, e_rpc); end end
         total++; if (q_has_dep_out !== e_qh || q_dep_out !== {e_qd[1], e_qd[0]} || q_val_out !== {e_qv[1], e_qv[0]}) begin bad++; $display("FAIL rnd_query cyc=%0d got=%b/%h/%h want=%b/%h/%h", i, q_has_dep_out, q_dep_out, q_val_out, e_qh, {e_qd[1], e_qd[0]}, {e_qv[1], e_qv[0]}); end
      end
      idle();
   endtask

   initial begin
      rst_n_in = 1'b0;
      idle();
      test_reset();
      test_fill();
      test_dual_commit();
      test_mispredict();
      test_query_bypass();
      test_store_pair();
      test_random(800);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
